// File: rtl/mul_pkg.sv
// mul_pkg: shared multiplier types and sizing helpers
//   state_t   : IDLE / CALC / DONE sequencer states, 2-bit encoding
//   cnt_width : bits needed for an iteration counter that runs WIDTH-1 down to 0
package mul_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
   function automatic int cnt_width(input int w);
      return $clog2(w);
   endfunction
endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative radix-2 shift-add multiplier, signed or unsigned
//   clk, rst         : clock, asynchronous active-high reset
//   start, is_signed : request and mode, sampled in IDLE with operands a, b
//   busy, done       : busy in CALC/DONE, done pulses one cycle with a valid product
//   product          : 2*WIDTH result register, written only on CALC->DONE
module seq_multiplier
   import mul_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 is_signed,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);
   localparam int CW = cnt_width(WIDTH);
   state_t               state_q, state_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d, mcand_q, mcand_d, prod_q, prod_d, acc_sum;
   logic [WIDTH-1:0]     mplier_q, mplier_d, mag_a, mag_b;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 neg_q, neg_d;
   // The most-negative operand negates to itself, which is its correct unsigned magnitude.
   assign mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
   assign mag_b = (is_signed && b[WIDTH-1]) ? -b : b;
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      prod_d   = prod_q;
      acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
      case (state_q)
         IDLE: if (start) begin
            mcand_d  = {{WIDTH{1'b0}}, mag_a};
            mplier_d = mag_b;
            neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_d    = '0;
            cnt_d    = CW'(WIDTH - 1);
            state_d  = CALC;
         end
         CALC: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               prod_d  = neg_q ? -acc_sum : acc_sum;
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         prod_q   <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         prod_q   <= prod_d;
      end
   end
   assign busy    = state_q != IDLE;
   assign done    = state_q == DONE;
   assign product = prod_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed and random checks of 32- and 8-bit seq_multiplier against an arithmetic model
module tb_seq_multiplier;
   logic        clk = 1'b0, rst = 1'b1;
   logic        st32 = 1'b0, s32 = 1'b0, st8 = 1'b0, s8 = 1'b0;
   logic [31:0] a32 = '0, b32 = '0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy32, done32, busy8, done8;
   logic [63:0] p32;
   logic [15:0] p8;
   int          checks = 0, errors = 0, cyc = 0, last_done, seen;
   logic [63:0] prev32 = '0, prev8 = '0;
   logic [31:0] ha [4] = '{32'd1234, 32'hFFFF_FFFF, 32'h8000_0000, 32'd77};
   logic [31:0] hb [4] = '{32'd5678, 32'd3, 32'h8000_0000, 32'hFFFF_FFF9};
   logic        hs [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
   logic [7:0]  corner [5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};

   seq_multiplier #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .start(st32), .is_signed(s32),
      .a(a32), .b(b32), .busy(busy32), .done(done32), .product(p32));
   seq_multiplier #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(st8), .is_signed(s8),
      .a(a8), .b(b8), .busy(busy8), .done(done8), .product(p8));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] ref_mul(input int w, input logic [63:0] a, input logic [63:0] b, input bit s);
      longint x, y;
      logic [63:0] wm, pm;
      wm = (64'd1 << w) - 64'd1;
      pm = (w >= 32) ? '1 : (64'd1 << (2 * w)) - 64'd1;
      x = longint'(a & wm);
      y = longint'(b & wm);
      if (s && a[w-1]) x = x - longint'(64'd1 << w);
      if (s && b[w-1]) y = y - longint'(64'd1 << w);
      return 64'(x * y) & pm;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic mul(input int w, input logic [63:0] a, input logic [63:0] b, input bit s,
                      input logic [63:0] exp, input string tag);
      int n;
      @(negedge clk);
      if (w == 32) begin a32 = a[31:0]; b32 = b[31:0]; s32 = s; st32 = 1'b1; end
      else begin a8 = a[7:0]; b8 = b[7:0]; s8 = s; st8 = 1'b1; end
      @(posedge clk); #1;
      st32 = 1'b0; st8 = 1'b0;
      a32 = $urandom; b32 = $urandom; s32 = ~s32; a8 = 8'($urandom); b8 = 8'($urandom); s8 = ~s8;
      check({tag, " busy"}, 64'(w == 32 ? busy32 : busy8), 64'd1);
      check({tag, " held"}, w == 32 ? p32 : {48'd0, p8}, w == 32 ? prev32 : prev8);
      n = 0;
      while (!(w == 32 ? done32 : done8) && n < 200) begin @(posedge clk); #1; n++; end
      check({tag, " latency"}, 64'(n), 64'(w));
      check({tag, " product"}, w == 32 ? p32 : {48'd0, p8}, exp);
      if (w == 32) prev32 = exp; else prev8 = exp;
      @(posedge clk); #1;
      check({tag, " pulse"}, 64'(w == 32 ? {done32, busy32} : {done8, busy8}), 64'd0);
   endtask

   initial begin
      #12;
      check("reset state", {p32[31:0], 16'(p8), 13'd0, busy32, done32, busy8}, 64'd0);
      @(negedge clk); rst = 1'b0;
      mul(32, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "u32 max");
      mul(32, 64'hFFFF_FFFD, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, "s32 -3*5");
      mul(32, 64'hFFFF_FFFD, 64'd5, 1'b0, 64'h0000_0004_FFFF_FFF1, "u32 fffffffd*5");
      mul(32, 64'h8000_0000, 64'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "s32 min*min");
      mul(32, 64'h8000_0000, 64'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, "s32 min*1");
      mul(32, 64'd0, 64'hDEAD_BEEF, 1'b1, 64'd0, "s32 zero");
      // asynchronous reset in the middle of an operation
      @(negedge clk); a32 = 32'd7; b32 = 32'd9; s32 = 1'b0; st32 = 1'b1;
      @(posedge clk); #1; st32 = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst = 1'b1; #1;
      check("async rst", {p32[31:0], 30'd0, busy32, done32}, 64'd0);
      @(negedge clk); rst = 1'b0; prev32 = '0; prev8 = '0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin @(negedge clk); if (done32) seen++; end
      check("no done after rst", 64'(seen), 64'd0);
      mul(32, 64'd7, 64'd9, 1'b0, 64'd63, "u32 after rst");
      // start held high: back-to-back operations, operands taken only at capture
      @(negedge clk); a32 = ha[0]; b32 = hb[0]; s32 = hs[0]; st32 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         int n;
         @(posedge clk); #1;
         check("hs capture busy", 64'(busy32), 64'd1);
         a32 = $urandom; b32 = $urandom; s32 = ~s32;
         n = 0;
         while (!done32 && n < 200) begin @(posedge clk); #1; n++; end
         check("hs latency", 64'(n), 64'd32);
         check("hs product", p32, ref_mul(32, 64'(ha[k]), 64'(hb[k]), hs[k]));
         if (k > 0) check("hs period", 64'(cyc - last_done), 64'd34);
         last_done = cyc;
         if (k < 3) begin a32 = ha[k+1]; b32 = hb[k+1]; s32 = hs[k+1]; end
         @(posedge clk); #1;
         check("hs idle", 64'({done32, busy32}), 64'd0);
         if (k == 3) st32 = 1'b0;
      end
      prev32 = ref_mul(32, 64'(ha[3]), 64'(hb[3]), hs[3]);
      repeat (3) @(posedge clk);
      for (int i = 0; i < 60; i++) begin
         logic [63:0] x, y;
         bit s;
         x = 64'($urandom); y = 64'($urandom); s = 1'($urandom);
         mul(32, x, y, s, ref_mul(32, x, y, s), "rand32");
      end
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++)
            for (int s = 0; s < 2; s++)
               mul(8, 64'(corner[i]), 64'(corner[j]), 1'(s),
                   ref_mul(8, 64'(corner[i]), 64'(corner[j]), 1'(s)), "corner8");
      for (int i = 0; i < 300; i++) begin
         logic [63:0] x, y;
         bit s;
         x = 64'($urandom_range(0, 255)); y = 64'($urandom_range(0, 255)); s = 1'($urandom);
         mul(8, x, y, s, ref_mul(8, x, y, s), "rand8");
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised, iterative radix-2 shift-add multiplier; successor to the combinational 32x32 array multiplier.
- Adds a signed/unsigned mode select, a start/busy/done handshake and a registered result, at the cost of a fixed multi-cycle latency.
- Sits beside the ALU and serves MUL/MULH-style ops where area matters more than single-cycle latency.

Parameters:
- WIDTH, 32: operand width in bits; legal range 4..64; product is 2*WIDTH bits.

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; captured with start
- a  in  WIDTH  multiplicand; captured with start
- b  in  WIDTH  multiplier; captured with start
- busy  out  1  high in CALC and DONE
- done  out  1  one-cycle pulse; product valid
- product  out  2*WIDTH  result register; holds its value until the next result is written

Behaviour:
- Reset (async, any state, including mid-operation):
  - state = IDLE.
  - busy = 0, done = 0, product = 0.
  - Internal accumulator, multiplicand, multiplier and counter registers = 0.
  - The in-flight operation is discarded; no done is generated for it.
- States: IDLE, CALC, DONE.
- IDLE, on an edge with start = 1:
  - Capture operands as magnitudes: if is_signed and an operand's MSB = 1, store its two's-complement negation, else store it raw.
  - Record neg = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]).
  - Load the multiplicand into a 2*WIDTH-bit shift register, zero-extended.
  - Clear the accumulator, set counter = WIDTH-1, go to CALC.
  - If start = 0, stay in IDLE.
- CALC, on each edge:
  - If multiplier LSB = 1, add the multiplicand register to the accumulator. Width is 2*WIDTH; no overflow is possible.
  - Shift the multiplicand register left 1 and the multiplier register right 1.
  - When counter = 0, write product = neg ? -(acc_next) : acc_next and go to DONE. Otherwise decrement the counter.
- DONE: done = 1 for exactly this cycle; next edge goes to IDLE unconditionally.
- Latency:
  - Capture edge E0; WIDTH iteration edges E1..EWIDTH.
  - done is high in the cycle after EWIDTH.
  - Next start is accepted at the edge ending the DONE cycle + 1, i.e. once in IDLE.
  - Throughput: one multiply per WIDTH+2 cycles.
- start while busy = 1 is ignored and not queued; operand inputs are don't-care while busy.
- Edge cases:
  - Most-negative operand: the magnitude 2^(WIDTH-1) fits in WIDTH unsigned bits.
  - Signed min*min = 2^(2*WIDTH-2) fits the 2*WIDTH signed product.
- Zero operands take the same fixed latency; there is no early exit.
- The product register changes only on the CALC->DONE edge or on reset.

Decomposition:
- Shared package mul_pkg holds:
  - the state typedef (IDLE, CALC, DONE), 2-bit encoding;
  - a localparam for the counter width, $clog2(WIDTH).
- No sub-module is required; the datapath is one accumulator and two shift registers.
- The sign conditioning (conditional negate) may be a function in mul_pkg so the future divider can reuse it.

Test Plan:
- Reset mid-CALC: start with a = 7, b = 9, assert rst 5 cycles later.
  - Required: busy = 0, done = 0, product = 0 immediately (asynchronously).
  - No done pulse follows.
  - A fresh start then completes normally.
- Unsigned, WIDTH = 32: a = 0xFFFFFFFF, b = 0xFFFFFFFF, is_signed = 0.
  - Required: product = 0xFFFFFFFE00000001.
  - done high exactly 33 cycles after the capture edge's cycle; single-cycle pulse.
- Signed mixed: a = -3 (0xFFFFFFFD), b = 5, is_signed = 1.
  - Required: product = 0xFFFFFFFFFFFFFFF1 (-15).
  - Same inputs with is_signed = 0 give 0x00000004FFFFFFF1.
- Signed extreme: a = b = 0x80000000, is_signed = 1.
  - Required: product = 0x4000000000000000.
  - a = 0x80000000, b = 1 gives 0xFFFFFFFF80000000.
- Handshake: hold start = 1 continuously with changing operands.
  - Required: operations complete every 34 cycles; each uses the operands present on its capture edge.
  - Mid-operation operand changes have no effect; product is stable between done pulses.
- Parameter sweep, WIDTH = 8: exhaustive 256x256 signed and unsigned.
  - Required: every result matches the reference model.
  - Latency is 9 cycles to done.
